// File: rtl/data_memory_lsu_if.sv
// Request/response bundle for the data memory LSU.
// Master drives requests; slave returns one registered response per accept.
interface data_memory_lsu_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_fault;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

// File: rtl/data_memory_lsu.sv
// Data memory LSU: RISC-V byte/half/word access, 1-cycle registered response.
// DMEM_CLEAR_ON_RESET_EN builds the post-reset zeroing sweep.
module data_memory_lsu #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   data_memory_lsu_if.slave     bus,
   output logic                 busy
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] ridx;
   logic [1:0]    lane;
   logic [2:0]    f3;
   logic          acc;
   logic          oor;
   logic          mis;
   logic          f3_ok;
   logic          fault;
   logic [31:0]   word;
   logic [7:0]    bsel;
   logic [15:0]   hsel;
   logic [31:0]   ld_data;

   logic          we;
   logic [AW-1:0] widx;
   logic [3:0]    wbe;
   logic [31:0]   wd;

   assign f3   = bus.req_funct3;
   assign lane = bus.req_addr[1:0];
   assign ridx = bus.req_addr[AW+1:2];

   assign bus.req_ready = !busy;
   // Reset has priority: a request seen at a reset edge is dropped.
   assign acc = bus.req_valid && bus.req_ready && !reset;

   assign oor = bus.req_addr >= ADDR_W'(4 * DEPTH);
   assign mis = (f3[1:0] == 2'b01 && lane[0])
             || (f3[1:0] == 2'b10 && lane != 2'b00);

   always_comb begin
      f3_ok = 1'b0;
      if (bus.req_write)
         f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      else
         f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010)
              || (f3 == 3'b100) || (f3 == 3'b101);
   end

   assign fault = oor || mis || !f3_ok;

   assign word = mem[ridx];
   assign bsel = 8'(word >> {lane, 3'b000});
   assign hsel = lane[1] ? word[31:16] : word[15:0];

   always_comb begin
      ld_data = 32'h0;
      case (f3)
         3'b000:  ld_data = {{24{bsel[7]}}, bsel};
         3'b001:  ld_data = {{16{hsel[15]}}, hsel};
         3'b010:  ld_data = word;
         3'b100:  ld_data = {24'h0, bsel};
         3'b101:  ld_data = {16'h0, hsel};
         default: ld_data = 32'h0;
      endcase
   end

`ifdef DMEM_CLEAR_ON_RESET_EN
   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] cnt_q;
   logic [AW-1:0] cnt_d;
   logic          clr_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         S_CLEAR: begin
            busy   = 1'b1;
            clr_we = !reset;
            cnt_d  = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1))
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
`else
   logic          clr_we;
   logic [AW-1:0] cnt_q;

   assign busy   = 1'b0;
   assign clr_we = 1'b0;
   assign cnt_q  = '0;
`endif

   // One write port shared by the clear sweep and stores.
   always_comb begin
      we   = 1'b0;
      widx = ridx;
      wbe  = 4'b0000;
      wd   = bus.req_wdata;
      if (clr_we) begin
         we   = 1'b1;
         widx = cnt_q;
         wbe  = 4'b1111;
         wd   = 32'h0;
      end else if (acc && bus.req_write && !fault) begin
         we = 1'b1;
         case (f3[1:0])
            2'b00: begin
               wbe = 4'b0001 << lane;
               wd  = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
               wbe = lane[1] ? 4'b1100 : 4'b0011;
               wd  = {2{bus.req_wdata[15:0]}};
            end
            default: begin
               wbe = 4'b1111;
               wd  = bus.req_wdata;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && wbe[i])
            mem[widx][8*i +: 8] <= wd[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 32'h0;
         bus.rsp_fault <= 1'b0;
      end else begin
         bus.rsp_valid <= acc;
         bus.rsp_fault <= acc && fault;
         bus.rsp_rdata <= (acc && !bus.req_write && !fault)
                        ? ld_data : 32'h0;
      end
   end
endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised successor data memory for the RISC-V datapath.
- Adds a valid/ready request port and a registered read with 1-cycle latency.
- Supports RISC-V byte, halfword and word loads/stores (funct3-encoded) with sign/zero extension and byte-lane writes.
- Flags misaligned, out-of-range and illegal-funct3 accesses as faults.
- Optional hardware clear sweep after reset.
- Sits between the EX/MEM stage and WB.

Parameters:
- ADDR_W, 32, width of the byte address input.
- DEPTH, 64, number of 32-bit words; must be a power of 2, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; equals !busy, combinational.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 access size/sign.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; the low bytes are used for SB/SH.
- rsp_valid  output  1  response valid; one-cycle pulse per accepted request.
- rsp_rdata  output  32  load result after extension; 0 for stores and faults.
- rsp_fault  output  1  the accepted request faulted; qualified by rsp_valid.
- busy  output  1  clear sweep in progress.

Behaviour:
- Storage: DEPTH x 32-bit array. Word index is req_addr[log2(DEPTH)+1:2]. Byte lane is req_addr[1:0], little-endian.
- Accept: a request is accepted when req_valid && req_ready at a rising edge. One request can be accepted per cycle, fully pipelined. The response has no backpressure.
- Latency: rsp_valid, rsp_rdata and rsp_fault are registered. They are valid in the cycle after acceptance. When no request is accepted, rsp_valid=0, and rsp_rdata and rsp_fault return to 0.
- Loads:
  - 000 LB: sign-extend the addressed byte.
  - 001 LH: sign-extend the addressed halfword.
  - 010 LW: the full word.
  - 100 LBU: zero-extend the addressed byte.
  - 101 LHU: zero-extend the addressed halfword.
- Stores:
  - 000 SB: writes only the addressed byte lane.
  - 001 SH: writes only the addressed halfword lanes.
  - 010 SW: writes all 4 lanes.
  - The write takes effect at the accepting edge.
- Fault conditions (rsp_fault=1 with rsp_rdata=0, and no memory modification):
  - req_addr >= 4*DEPTH.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the updated data. A single-cycle load/store cannot overlap, because the store writes at the same edge the load samples, and each op is a single request.
- States: CLEAR and IDLE.
  - IDLE: busy=0.
  - CLEAR: busy=1. A word counter runs from 0 to DEPTH-1, writing 0 to one word per cycle. After the word DEPTH-1 write, the state goes to IDLE on the next edge, so busy is high for exactly DEPTH cycles after reset deasserts.
- Reset (synchronous):
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - Clear counter = 0.
  - The state goes to CLEAR or IDLE as defined under Optional Feature.
  - Reset asserted mid-sweep restarts the counter at 0.
  - Requests presented while busy are not accepted and get no response.
  - A reset in the cycle after acceptance suppresses that response.

Optional Feature:
- Macro: DMEM_CLEAR_ON_RESET_EN.
- Defined:
  - Reset puts the state in CLEAR; busy=1 from the first edge with reset high.
  - The sweep zeroes all DEPTH words, then the state goes to IDLE.
  - Contents read 0 after the sweep.
- Undefined:
  - The CLEAR state and counter are not built; reset puts the state in IDLE.
  - busy is tied to 0, and req_ready=1 in the first cycle after reset.
  - Memory contents are not affected by reset (undefined after power-up).

Test Plan:
- With EN, DEPTH=64: assert reset for 1 cycle, then hold req_valid=1 -> busy=1 and req_ready=0 for exactly 64 cycles. After that, LW 0x10 returns rsp_rdata=0x00000000 with rsp_fault=0, one cycle after accept.
- SW 0x800080FF to 0x4, then:
  - LB 0x4 -> 0xFFFFFFFF.
  - LBU 0x4 -> 0x000000FF.
  - LH 0x6 -> 0xFFFF8000.
  - LHU 0x6 -> 0x00008000.
  - LW 0x4 -> 0x800080FF.
- SW 0x0 to 0x8, SB 0x12345678AB to 0x9 (low byte 0xAB), SH 0xBEEF to 0xA, then LW 0x8 -> 0xBEEFAB00.
- Faults:
  - LW 0x2 -> rsp_fault=1, rdata=0.
  - SH 0x5 with data 0xFFFF, then LW 0x4 -> word unchanged.
  - LW 0x100 -> fault.
  - Load funct3=011 -> fault.
- Back-to-back SW 0xCAFEF00D to 0x20, then LW 0x20 in the next cycle -> 0xCAFEF00D. Also issue 8 consecutive LWs and check 8 consecutive rsp_valid pulses in order.
- With EN: assert reset at cycle 30 of the sweep -> the counter restarts, and busy stays high for 64 more cycles after reset deasserts. A request accepted the cycle before reset produces no rsp_valid.
